// File: rtl/rr_arb8_enc.sv
// rr_arb8_enc: 8-line round-robin arbiter with one-hot grant and 3-bit encoded index.
// Optional owner hold limit with preemption when RR_ARB8_TIMEOUT_EN is defined.
`default_nettype none

module rr_arb8_enc #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       preempt
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] last_q, last_d;
   logic [2:0] owner;
   logic [7:0] arb_req;
   logic       do_arb;
   logic       found;
   logic [2:0] win;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arb8_enc: MAX_HOLD must be in 2..255");
   end

`ifdef RR_ARB8_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;
`endif

   // Owner index follows the same OR encoding as the downstream 8-to-3 encoder.
   assign owner   = {gnt_q[4] | gnt_q[5] | gnt_q[6] | gnt_q[7],
                     gnt_q[2] | gnt_q[3] | gnt_q[6] | gnt_q[7],
                     gnt_q[1] | gnt_q[3] | gnt_q[5] | gnt_q[7]};
   assign gnt     = gnt_q;
   assign gnt_idx = owner;
   assign gnt_vld = |gnt_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      arb_req = req;
      do_arb  = 1'b0;
      found   = 1'b0;
      win     = 3'd0;
`ifdef RR_ARB8_TIMEOUT_EN
      hold_d    = hold_q;
      preempt_d = 1'b0;
`endif
      case (state_q)
         IDLE: do_arb = |req;
         BUSY: begin
            if (!req[owner]) begin
               do_arb = 1'b1;
`ifdef RR_ARB8_TIMEOUT_EN
            end else if (hold_q == HOLD_LAST) begin
               do_arb         = 1'b1;
               arb_req[owner] = 1'b0;
               preempt_d      = 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Scan starts one past the last winner and wraps modulo 8.
      for (int i = 1; i <= 8; i++) begin
         if (!found && arb_req[last_q + 3'(i)]) begin
            found = 1'b1;
            win   = last_q + 3'(i);
         end
      end

      if (do_arb) begin
         if (found) begin
            state_d = BUSY;
            gnt_d   = 8'b1 << win;
            last_d  = win;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_d  = 8'd0;
         end else if (preempt_d) begin
            hold_d  = 8'd0;
`endif
         end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 8'h00;
         last_q  <= 3'd7;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

`ifdef RR_ARB8_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb8_enc.sv
// tb_rr_arb8_enc: table and scoreboard bench for rr_arb8_enc (MAX_HOLD=4).
`default_nettype none

module tb_rr_arb8_enc;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] req;
      logic [7:0] gnt;
      logic       pre;
   } vec_t;

   typedef struct {
      logic [7:0] gnt;
      logic       pre;
      string      name;
   } exp_t;

   vec_t tbl[32];
   exp_t sb[$];

`ifdef RR_ARB8_TIMEOUT_EN
   localparam int HOLD_N = 3;
`else
   localparam int HOLD_N = 10;
`endif

   rr_arb8_enc #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] enc(input logic [7:0] g);
      return {g[4] | g[5] | g[6] | g[7], g[2] | g[3] | g[6] | g[7], g[1] | g[3] | g[5] | g[7]};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [7:0] eg, input logic ep);
      chk({name, ".gnt"}, gnt, eg);
      chk({name, ".idx"}, {5'd0, gnt_idx}, {5'd0, enc(eg)});
      chk({name, ".vld"}, {7'd0, gnt_vld}, {7'd0, |eg});
      chk({name, ".pre"}, {7'd0, preempt}, {7'd0, ep});
   endtask

   task automatic step(input string name, input logic [7:0] r, input logic [7:0] eg, input logic ep);
      exp_t e;
      @(negedge clk);
      req = r;
      sb.push_back('{gnt: eg, pre: ep, name: name});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_out(e.name, e.gnt, e.pre);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      req = 8'h00;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 3; j++)
            tbl[i*4 + j] = '{req: 8'b1 << i, gnt: 8'b1 << i, pre: 1'b0};
         tbl[i*4 + 3] = '{req: 8'h00, gnt: 8'h00, pre: 1'b0};
      end

      rst = 1'b1;
      req = 8'hFF;
      #3;
      chk_out("reset_async", 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset_hold", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req = 8'h00;

      for (int i = 0; i < 5; i++) step("idle", 8'h00, 8'h00, 1'b0);

      for (int i = 0; i < 32; i++) step($sformatf("enc%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].pre);

      // Each owner holds two cycles, then drops for one cycle; handoff is back-to-back.
      step("rr_first", 8'hFF, 8'h01, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step($sformatf("rr_hold%0d", k), 8'hFF, 8'b1 << k, 1'b0);
         step($sformatf("rr_next%0d", k), 8'hFF & ~(8'b1 << k), 8'b1 << ((k + 1) % 8), 1'b0);
      end
      step("rr_idle", 8'h00, 8'h00, 1'b0);

      for (int i = 0; i < HOLD_N; i++) step("hold6", 8'hC1, 8'h40, 1'b0);
      step("to7", 8'h81, 8'h80, 1'b0);
      step("hold7", 8'h81, 8'h80, 1'b0);
      step("wrap0", 8'h01, 8'h01, 1'b0);
      step("wrap_idle", 8'h00, 8'h00, 1'b0);

      step("own5", 8'h21, 8'h20, 1'b0);
      step("own5_hold", 8'h21, 8'h20, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk_out("mid_reset", 8'h00, 1'b0);
      #1;
      rst = 1'b0;
      step("post_reset", 8'h21, 8'h01, 1'b0);
      step("post_idle", 8'h00, 8'h00, 1'b0);

`ifdef RR_ARB8_TIMEOUT_EN
      pulse_reset();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 4; i++) step("to_own0", 8'h03, 8'h01, (c == 1 && i == 0));
         for (int i = 0; i < 4; i++) step("to_own1", 8'h03, 8'h02, (i == 0));
      end
      step("to_back0", 8'h03, 8'h01, 1'b1);
      step("to_idle", 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 12; i++) step("to_solo", 8'h01, 8'h01, (i == 4 || i == 8));
      step("to_solo_idle", 8'h00, 8'h00, 1'b0);
`else
      pulse_reset();
      for (int i = 0; i < 20; i++) step("no_to_hold", 8'h03, 8'h01, 1'b0);
      step("no_to_idle", 8'h00, 8'h00, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
